bcd_mux_timer: RTL
==================

// Module: bcd_mux_timer
// PURPOSE
//   Parametrised N-digit BCD up/down timer with debounced increment/clear buttons,
//   a run gate, a prescaled 1-unit tick, a sticky done flag and a time-multiplexed
//   common-cathode 7-segment driver (one segment bus, one-hot digit enables).
//   Sits between the ui_in/uio pins and the display. Supersedes the fixed 2-digit timer.
// PARAMETERS
//   NUM_DIGITS       4          BCD digits (2..8); digit 0 = least significant
//   TICK_DIV         6000000    clk cycles per count tick (>=2)
//   DEBOUNCE_CYCLES  1000       consecutive high cycles before a button is stable (>=2)
//   MUX_DIV          1024       clk cycles each digit is displayed (>=2)
// PORTS
//   clk        in   1               system clock
//   rst        in   1               synchronous reset, active high
//   btn_inc    in   1               raw button: +1 to count
//   btn_clr    in   1               raw button: clear count and done
//   run        in   1               1 = prescaler runs, ticks apply
//   up_dn      in   1               1 = count up, 0 = count down
//   seg        out  7               {a,b,c,d,e,f,g}, 1 = segment lit
//   dig_en     out  NUM_DIGITS      one-hot digit enable, bit i = digit i
//   done       out  1               sticky: down reached 0 or up reached all-9s
//   count_bcd  out  4*NUM_DIGITS    current count, digit i at [4i+3:4i]
// BEHAVIOUR
//   Reset (rst=1 at clk edge): count=0, done=0, prescaler=0, debounce counters=0,
//     stable flags=0, mux index=0, mux counter=0 -> dig_en=1, seg=7'b1111110.
//   Debounce (per button): raw=1 increments counter; at DEBOUNCE_CYCLES-1 stable<=1
//     and counter holds; raw=0 clears counter and stable in the same cycle.
//     Event = stable rising edge (stable & ~stable_d), exactly one per press.
//   Prescaler: run=0 -> held at 0, no tick. run=1 -> counts 0..TICK_DIV-1; tick is
//     a 1-cycle pulse in the cycle the prescaler equals TICK_DIV-1, which wraps it to 0.
//   Count update priority per cycle (exactly one applies): clr event > tick > inc event.
//     clr: count=0, done=0. Inc event coinciding with a tick is dropped.
//     tick, up_dn=0: count==0 -> hold; else BCD decrement with borrow; result 0 -> done=1.
//     tick, up_dn=1: count==all-9s -> hold; else BCD increment with carry; result
//       all-9s -> done=1.
//     inc event: BCD increment, all-9s wraps to 0; clears done. Not gated by run.
//   BCD rule: each digit stays 0..9; carry/borrow ripple within one cycle; no
//     binary intermediate. up_dn may change at any time; applies to the next tick.
//   Display mux: counter 0..MUX_DIV-1; at MUX_DIV-1 index advances, NUM_DIGITS-1
//     wraps to 0. dig_en = 1<<index; seg = decode(count digit[index]), combinational
//     from registered index and count (zero latency). Decode 0-9 standard; 10-15 -> 0.
//   done, count_bcd are registered; count changes 1 cycle after the causing edge/tick.
//   Reset mid-press: stable cleared; a still-held button must re-debounce and then
//     produces one event.
// CONFIGURATION
//   BCD_TIMER_LZB_EN defined: leading-zero blanking. Digit i>0 shows seg=0 when it and
//     all higher digits are 0; digit 0 always shown; dig_en unaffected.
//   Undefined: all digits always decoded (zeros shown as '0').
// TESTING  (NUM_DIGITS=2, TICK_DIV=10, DEBOUNCE_CYCLES=4, MUX_DIV=4)
//   rst 1 cycle -> count=8'h00, done=0, dig_en=2'b01, seg=7'b1111110.
//   btn_inc high 3 cycles then low -> no change; high 4 cycles -> count=8'h01 once,
//     holding high 20 more cycles -> still 8'h01.
//   12 inc presses from 8'h95 -> 8'h99 then 8'h00, 8'h01 ... 8'h07 (wrap).
//   count=8'h10, up_dn=0, run=1 -> after 10 clks 8'h09; after 100 more 8'h00, done=1;
//     further ticks hold 8'h00; clr event -> done=0.
//   inc event in same cycle as tick (count=8'h05, down) -> 8'h04, inc dropped;
//     clr and tick same cycle -> 8'h00.
//   count=8'h42, run=0 -> dig_en 01,10,01 every 4 clks, seg 1101101/0110011;
//     with BCD_TIMER_LZB_EN, count=8'h07 -> tens slot seg=0.

Source files
------------

// File: rtl/bcd_mux_timer.sv
// bcd_mux_timer
//   N-digit BCD up/down timer. Two raw buttons are debounced, and each clean
//   press produces one event: btn_inc adds one to the count, btn_clr clears the
//   count and the done flag. While run is high, a prescaler produces a one-cycle
//   tick every TICK_DIV clocks. Each tick counts up or down according to up_dn
//   and saturates at the end of the range. The count is shown on a
//   time-multiplexed common-cathode 7-segment display.
//
// Optional feature: define BCD_TIMER_LZB_EN to enable leading-zero blanking.
//   A digit i>0 is blanked when it and all higher digits are zero. Digit 0 is
//   always shown, and dig_en is not affected.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active high
//   btn_inc    in   raw button, +1 to count (not gated by run)
//   btn_clr    in   raw button, clears count and done
//   run        in   1 = prescaler runs and ticks apply
//   up_dn      in   1 = ticks count up, 0 = ticks count down
//   seg        out  {a,b,c,d,e,f,g}, 1 = lit, for the digit selected by dig_en
//   dig_en     out  one-hot digit enable, bit i = digit i
//   done       out  sticky: down reached 0 or up reached all-9s
//   count_bcd  out  current count, digit i at [4i+3:4i]
module bcd_mux_timer #(
  parameter int NUM_DIGITS      = 4,
  parameter int TICK_DIV        = 6000000,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int MUX_DIV         = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_inc,
  input  logic                    btn_clr,
  input  logic                    run,
  input  logic                    up_dn,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] count_bcd
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int MW = $clog2(MUX_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  // Ripple-carry BCD increment: every digit stays in 0..9, and all-9s wraps to 0.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Ripple-borrow BCD decrement. Callers never pass 0.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic is_all9(input logic [W-1:0] v);
    logic r;
    r = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd9) r = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b1111110;  // 0, and 10..15 shown as 0
    endcase
    return s;
  endfunction

  // Debounce. Index 0 is btn_inc, and index 1 is btn_clr.
  logic [1:0]    raw;
  logic [1:0]    stable;
  logic [1:0]    stable_d;
  logic [DW-1:0] db_cnt [2];

  assign raw = {btn_clr, btn_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      stable   <= 2'b00;
      stable_d <= 2'b00;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      stable_d <= stable;
      for (int i = 0; i < 2; i++) begin
        if (!raw[i]) begin
          db_cnt[i] <= '0;
          stable[i] <= 1'b0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= 1'b1;  // counter holds here until release
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  logic inc_ev;
  logic clr_ev;
  assign inc_ev = stable[0] & ~stable_d[0];
  assign clr_ev = stable[1] & ~stable_d[1];

  // Prescaler. It is held at 0 while stopped, so each run starts a full period.
  logic [TW-1:0] presc;
  logic          tick;
  assign tick = run && (presc == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || !run || tick) presc <= '0;
    else                     presc <= presc + TW'(1);
  end

  // Count and done. Priority is clr > tick > inc, so an inc event in a tick
  // cycle is lost.
  logic [W-1:0] count;
  logic [W-1:0] cnt_up;
  logic [W-1:0] cnt_dn;
  assign cnt_up = bcd_inc(count);
  assign cnt_dn = bcd_dec(count);

  always_ff @(posedge clk) begin
    if (rst || clr_ev) begin
      count <= '0;
      done  <= 1'b0;
    end else if (tick) begin
      if (up_dn) begin
        if (!is_all9(count)) begin
          count <= cnt_up;
          if (is_all9(cnt_up)) done <= 1'b1;
        end
      end else begin
        if (count != '0) begin
          count <= cnt_dn;
          if (cnt_dn == '0) done <= 1'b1;
        end
      end
    end else if (inc_ev) begin
      count <= cnt_up;
      done  <= 1'b0;
    end
  end

  assign count_bcd = count;

  // Display multiplexer.
  logic [MW-1:0] mux_cnt;
  logic [IW-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_cnt <= '0;
      idx     <= '0;
    end else if (mux_cnt == MW'(MUX_DIV - 1)) begin
      mux_cnt <= '0;
      idx     <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      mux_cnt <= mux_cnt + MW'(1);
    end
  end

  assign dig_en = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;

  logic [3:0] cur_digit;
  logic       blank;
  assign cur_digit = count[4*idx +: 4];

  always_comb begin
    blank = 1'b0;
`ifdef BCD_TIMER_LZB_EN
    // Blank only if the current digit and every higher digit are zero.
    blank = (idx != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && count[4*i +: 4] != 4'd0) blank = 1'b0;
    end
`endif
  end

  assign seg = blank ? 7'b0000000 : decode(cur_digit);

endmodule
